// File: rtl/pmod_mux_pkg.sv
// Shared definitions for the PMOD pin mux: mode encodings, FSM states, pad indices.
package pmod_mux_pkg;

    localparam logic [2:0] MODE_UART = 3'b000;
    localparam logic [2:0] MODE_SPI  = 3'b001;
    localparam logic [2:0] MODE_GPIO = 3'b010;
    localparam logic [2:0] MODE_I2C  = 3'b011;
    localparam logic [2:0] MODE_OFF  = 3'b111;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    // Pad indices; several functions share a pad depending on the mode
    localparam int PIN_SS   = 0;
    localparam int PIN_MOSI = 1;
    localparam int PIN_RX   = 1;
    localparam int PIN_MISO = 2;
    localparam int PIN_TX   = 2;
    localparam int PIN_SCL  = 2;
    localparam int PIN_SCK  = 3;
    localparam int PIN_SDA  = 3;

    // Any encoding with the top bit set collapses onto OFF
    function automatic logic [2:0] norm_mode(input logic [2:0] m);
        return m[2] ? MODE_OFF : m;
    endfunction

endpackage

// File: rtl/pmod_in_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs.
module pmod_in_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the raw pad value through the flop chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pmod_port_mux_sync.sv
// Registered PMOD pad mux with a drain/guard handshake on every mode change.
module pmod_port_mux_sync
    import pmod_mux_pkg::*;
#(
    parameter int PINS         = 8,
    parameter int GUARD_CYCLES = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      mode_req,
    input  logic            mode_req_valid,
    output logic            mode_ack,
    output logic [2:0]      mode_active,
    output logic            busy,
    input  logic            uart_tx,
    output logic            uart_rx,
    input  logic            spi_ss,
    input  logic            spi_mosi,
    input  logic            spi_sck,
    output logic            spi_miso,
    input  logic            i2c_scl_o,
    input  logic            i2c_sda_o,
    output logic            i2c_scl_i,
    output logic            i2c_sda_i,
    input  logic [PINS-1:0] gpio_out,
    input  logic [PINS-1:0] gpio_dir,
    output logic [PINS-1:0] gpio_in,
    output logic [PINS-1:0] pin_o,
    output logic [PINS-1:0] pin_oe,
    input  logic [PINS-1:0] pin_i
);

    localparam int CNT_W = $clog2(GUARD_CYCLES + 1);

    state_t          state, state_nxt;
    logic [2:0]      mode_nxt;
    logic [2:0]      req_lat, req_lat_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic            ack_nxt;
    logic [PINS-1:0] pad_o_nxt, pad_oe_nxt;
    logic [PINS-1:0] sync_q;
    logic [2:0]      req_norm;
    logic            in_active;

    assign req_norm = norm_mode(mode_req);

    // FSM, mode, guard counter and ack registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ACTIVE;
            mode_active <= MODE_OFF;
            req_lat     <= MODE_OFF;
            cnt         <= '0;
            mode_ack    <= 1'b0;
        end else begin
            state       <= state_nxt;
            mode_active <= mode_nxt;
            req_lat     <= req_lat_nxt;
            cnt         <= cnt_nxt;
            mode_ack    <= ack_nxt;
        end
    end

    // Next-state logic: same-mode requests ack at once, others drain then switch
    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_active;
        req_lat_nxt = req_lat;
        cnt_nxt     = cnt;
        ack_nxt     = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (mode_req_valid) begin
                    if (req_norm == mode_active) begin
                        ack_nxt = 1'b1;
                    end else begin
                        req_lat_nxt = req_norm;
                        cnt_nxt     = '0;
                        state_nxt   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt == CNT_W'(GUARD_CYCLES - 1)) state_nxt = ST_SWITCH;
                else                                 cnt_nxt   = cnt + 1'b1;
            end
            ST_SWITCH: begin
                mode_nxt  = req_lat;
                ack_nxt   = 1'b1;
                state_nxt = ST_ACTIVE;
            end
            default: state_nxt = ST_ACTIVE;
        endcase
    end

    // Pad map computed from the upcoming state so the new mode drives on the ack cycle
    always_comb begin
        pad_o_nxt  = '0;
        pad_oe_nxt = '0;
        if (state_nxt == ST_ACTIVE) begin
            case (mode_nxt)
                MODE_UART: begin
                    pad_oe_nxt[PIN_TX] = 1'b1;
                    pad_o_nxt[PIN_TX]  = uart_tx;
                end
                MODE_SPI: begin
                    pad_oe_nxt[PIN_SS]   = 1'b1;
                    pad_oe_nxt[PIN_MOSI] = 1'b1;
                    pad_oe_nxt[PIN_SCK]  = 1'b1;
                    pad_o_nxt[PIN_SS]    = spi_ss;
                    pad_o_nxt[PIN_MOSI]  = spi_mosi;
                    pad_o_nxt[PIN_SCK]   = spi_sck;
                end
                MODE_GPIO: begin
                    pad_oe_nxt = ~gpio_dir;
                    pad_o_nxt  = gpio_out;
                end
                MODE_I2C: begin
                    // Open drain: only ever pull low, release to let the bus float high
                    pad_oe_nxt[PIN_SCL] = ~i2c_scl_o;
                    pad_oe_nxt[PIN_SDA] = ~i2c_sda_o;
                end
                default: ;
            endcase
        end
    end

    // Registered pad outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_o  <= '0;
            pin_oe <= '0;
        end else begin
            pin_o  <= pad_o_nxt;
            pin_oe <= pad_oe_nxt;
        end
    end

    pmod_in_sync #(
        .WIDTH  (PINS),
        .STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_i),
        .q   (sync_q)
    );

    // Peripheral inputs see the pads only while their mode is settled and driving
    assign busy      = (state != ST_ACTIVE);
    assign in_active = (state == ST_ACTIVE);
    assign gpio_in   = sync_q;
    assign uart_rx   = (in_active && mode_active == MODE_UART) ? sync_q[PIN_RX]   : 1'b1;
    assign spi_miso  = (in_active && mode_active == MODE_SPI)  ? sync_q[PIN_MISO] : 1'b0;
    assign i2c_scl_i = (in_active && mode_active == MODE_I2C)  ? sync_q[PIN_SCL]  : 1'b1;
    assign i2c_sda_i = (in_active && mode_active == MODE_I2C)  ? sync_q[PIN_SDA]  : 1'b1;

endmodule

// File: tb/tb_pmod_port_mux_sync.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model.
module tb_pmod_port_mux_sync;

    localparam int PINS = 8;
    localparam int G    = 4;
    localparam int S    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      mode_req;
    logic            mode_req_valid;
    logic            mode_ack;
    logic [2:0]      mode_active;
    logic            busy;
    logic            uart_tx, uart_rx;
    logic            spi_ss, spi_mosi, spi_sck, spi_miso;
    logic            i2c_scl_o, i2c_sda_o, i2c_scl_i, i2c_sda_i;
    logic [PINS-1:0] gpio_out, gpio_dir, gpio_in;
    logic [PINS-1:0] pin_o, pin_oe, pin_i;

    pmod_port_mux_sync #(.PINS(PINS), .GUARD_CYCLES(G), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst),
        .mode_req(mode_req), .mode_req_valid(mode_req_valid),
        .mode_ack(mode_ack), .mode_active(mode_active), .busy(busy),
        .uart_tx(uart_tx), .uart_rx(uart_rx),
        .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_sck(spi_sck), .spi_miso(spi_miso),
        .i2c_scl_o(i2c_scl_o), .i2c_sda_o(i2c_sda_o),
        .i2c_scl_i(i2c_scl_i), .i2c_sda_i(i2c_sda_i),
        .gpio_out(gpio_out), .gpio_dir(gpio_dir), .gpio_in(gpio_in),
        .pin_o(pin_o), .pin_oe(pin_oe), .pin_i(pin_i)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: current mode, remaining busy cycles, pending target, pad history
    int              m_mode = 7;
    int              m_left = 0;
    int              m_req  = 7;
    logic            e_ack  = 1'b0;
    logic [PINS-1:0] e_o    = '0;
    logic [PINS-1:0] e_oe   = '0;
    logic [PINS-1:0] hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int norm(input logic [2:0] m);
        return (m >= 3'd4) ? 7 : int'(m);
    endfunction

    // Pad table straight from the mode description
    task automatic pad_map(input int mode, output logic [PINS-1:0] o, output logic [PINS-1:0] oe);
        o  = '0;
        oe = '0;
        case (mode)
            0: begin oe[2] = 1'b1; o[2] = uart_tx; end
            1: begin
                oe[0] = 1'b1; oe[1] = 1'b1; oe[3] = 1'b1;
                o[0] = spi_ss; o[1] = spi_mosi; o[3] = spi_sck;
            end
            2: begin oe = ~gpio_dir; o = gpio_out; end
            3: begin oe[2] = ~i2c_scl_o; oe[3] = ~i2c_sda_o; end
            default: ;
        endcase
    endtask

    task automatic model_edge();
        if (rst) begin
            m_mode = 7; m_left = 0; m_req = 7; e_ack = 1'b0;
            e_o = '0; e_oe = '0;
            hist.delete();
            for (int i = 0; i < S; i++) hist.push_back('0);
        end else begin
            e_ack = 1'b0;
            if (m_left == 0) begin
                if (mode_req_valid) begin
                    if (norm(mode_req) == m_mode) e_ack = 1'b1;
                    else begin m_req = norm(mode_req); m_left = G + 1; end
                end
            end else begin
                m_left--;
                if (m_left == 0) begin m_mode = m_req; e_ack = 1'b1; end
            end
            if (m_left != 0) begin e_o = '0; e_oe = '0; end
            else pad_map(m_mode, e_o, e_oe);
            hist.push_back(pin_i);
            void'(hist.pop_front());
        end
    endtask

    task automatic check_all();
        logic act;
        logic [PINS-1:0] g;
        act = (m_left == 0);
        g   = hist[0];
        chk("busy", busy, (m_left != 0));
        chk("mode_active", mode_active, m_mode[2:0]);
        chk("mode_ack", mode_ack, e_ack);
        chk("pin_o", pin_o, e_o);
        chk("pin_oe", pin_oe, e_oe);
        chk("gpio_in", gpio_in, g);
        chk("uart_rx", uart_rx, (act && m_mode == 0) ? g[1] : 1'b1);
        chk("spi_miso", spi_miso, (act && m_mode == 1) ? g[2] : 1'b0);
        chk("i2c_scl_i", i2c_scl_i, (act && m_mode == 3) ? g[2] : 1'b1);
        chk("i2c_sda_i", i2c_sda_i, (act && m_mode == 3) ? g[3] : 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic req_mode(input logic [2:0] m);
        mode_req = m; mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
        for (int i = 0; i < G + 1; i++) step();
    endtask

    initial begin
        int bcnt, ackat, acks;
        logic [PINS-1:0] oe_at_ack;
        rst = 1'b1; mode_req = 3'b000; mode_req_valid = 1'b0;
        uart_tx = 1'b0; spi_ss = 1'b0; spi_mosi = 1'b0; spi_sck = 1'b0;
        i2c_scl_o = 1'b1; i2c_sda_o = 1'b1;
        gpio_out = '0; gpio_dir = '1; pin_i = '0;
        #1;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_mode", mode_active, 3'b111);
        chk("rst_oe", pin_oe, 8'h00);
        chk("rst_uart_rx", uart_rx, 1'b1);

        // 1: first request, busy window and ack latency
        bcnt = 0; ackat = 0; oe_at_ack = '0;
        mode_req = 3'b001; mode_req_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            mode_req_valid = 1'b0;
            if (busy) bcnt++;
            if (mode_ack) begin ackat = i; oe_at_ack = pin_oe; end
        end
        chk("t1_busy_cycles", bcnt, 5);
        chk("t1_ack_cycle", ackat, 6);
        chk("t1_spi_oe", oe_at_ack, 8'h0B);

        // 2: UART TX path and RX synchroniser
        req_mode(3'b000);
        uart_tx = 1'b1; step();
        chk("t2_tx1", pin_o[2], 1'b1);
        uart_tx = 1'b0; step();
        chk("t2_tx0", pin_o[2], 1'b0);
        pin_i = 8'hFD; step(); step();
        chk("t2_rx", uart_rx, 1'b0);

        // 3: GPIO direction and input capture
        req_mode(3'b010);
        gpio_dir = 8'hF0; gpio_out = 8'hA5; pin_i = 8'h3C;
        step();
        chk("t3_oe", pin_oe, 8'h0F);
        chk("t3_o_low", pin_o[3:0], 4'h5);
        step();
        chk("t3_in", gpio_in, 8'h3C);

        // 4: I2C open-drain behaviour
        req_mode(3'b011);
        i2c_sda_o = 1'b1; step();
        chk("t4_sda_rel", pin_oe[3], 1'b0);
        i2c_sda_o = 1'b0; step();
        chk("t4_sda_low_oe", pin_oe[3], 1'b1);
        chk("t4_sda_low_o", pin_o[3], 1'b0);

        // 5: SPI -> GPIO with a second request arriving mid-drain
        req_mode(3'b001);
        acks = 0;
        mode_req = 3'b010; mode_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            mode_req_valid = (i == 1);
            mode_req = (i == 1) ? 3'b000 : 3'b010;
            if (mode_ack) acks++;
            if (busy) chk("t5_drain_oe", pin_oe, 8'h00);
        end
        chk("t5_ack_count", acks, 1);
        chk("t5_final_mode", mode_active, 3'b010);

        // 6: same-mode request, then reset during drain
        mode_req = 3'b010; mode_req_valid = 1'b1; step();
        mode_req_valid = 1'b0;
        chk("t6_same_ack", mode_ack, 1'b1);
        chk("t6_same_busy", busy, 1'b0);
        mode_req = 3'b001; mode_req_valid = 1'b1; step();
        mode_req_valid = 1'b0; step();
        rst = 1'b1; step();
        rst = 1'b0;
        chk("t6_rst_mode", mode_active, 3'b111);
        chk("t6_rst_oe", pin_oe, 8'h00);
        for (int i = 0; i < 6; i++) step();

        // Random traffic including invalid encodings and occasional reset
        for (int i = 0; i < 600; i++) begin
            mode_req       = 3'($urandom_range(0, 7));
            mode_req_valid = ($urandom_range(0, 5) == 0);
            rst            = ($urandom_range(0, 199) == 0);
            uart_tx   = 1'($urandom); spi_ss  = 1'($urandom);
            spi_mosi  = 1'($urandom); spi_sck = 1'($urandom);
            i2c_scl_o = 1'($urandom); i2c_sda_o = 1'($urandom);
            gpio_out  = 8'($urandom); gpio_dir = 8'($urandom);
            pin_i     = 8'($urandom);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
